camera_capture_ctrl: RTL

Frame capture sequencer for the 8-bit camera source. On a start command it drives camera_en to pull exactly IMG_W*IMG_H pixels from the camera. It tags each pixel with its x/y coordinates and sof/eol/eof flags, then hands pixels to the filter pipeline over a valid/ready interface. A 2-entry buffer and credit-based throttling of camera_en provide backpressure, because the camera has no ready input.

---
 rtl/cap_pkg.sv | 18 +
 rtl/pix_skid_fifo.sv | 38 +++
 rtl/camera_capture_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/cap_pkg.sv
// Shared types for the camera capture path: FSM states and the tagged pixel
// entry carried through the skid FIFO.
package cap_pkg;
    localparam int PIX_W   = 8;
    localparam int COORD_W = 16;

    typedef enum logic [1:0] {IDLE, CAPTURE, DONE, ABORT} cap_state_t;

    // Coordinates are stored at a fixed width; the top trims them to X_W/Y_W.
    typedef struct packed {
        logic [PIX_W-1:0]   data;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               sof;
        logic               eol;
        logic               eof;
    } pix_entry_t;
endpackage

// File: rtl/pix_skid_fifo.sv
// Two-entry pixel FIFO between the camera sampler and the filter handshake.
// Push and pop on a full buffer in the same cycle keep occupancy at two.
module pix_skid_fifo import cap_pkg::*; (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  pix_entry_t din,
    output pix_entry_t head,
    output logic [1:0] occ
);
    pix_entry_t mem [2];
    logic       rd_ptr;
    logic       wr_ptr;
    logic       do_push;
    logic       do_pop;

    assign do_pop  = pop && (occ != 2'd0);
    assign do_push = push && ((occ != 2'd2) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, do_push} - {1'b0, do_pop};
        end
    end
endmodule

// File: rtl/camera_capture_ctrl.sv
// Frame capture sequencer: paces camera_en by buffer credit, tags each pixel
// with coordinates and frame flags, and presents it over valid/ready.
module camera_capture_ctrl import cap_pkg::*; #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int X_W   = $clog2(IMG_W),
    parameter int Y_W   = $clog2(IMG_H)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    output logic           camera_en,
    input  logic           cam_valid,
    input  logic [7:0]     cam_data,
    output logic           pix_valid,
    input  logic           pix_ready,
    output logic [7:0]     pix_data,
    output logic [X_W-1:0] pix_x,
    output logic [Y_W-1:0] pix_y,
    output logic           pix_sof,
    output logic           pix_eol,
    output logic           pix_eof,
    output logic           busy,
    output logic           done,
    output logic           aborted,
    output logic [15:0]    frame_cnt,
    output logic           proto_err
);
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int CNT_W = $clog2(NPIX + 1);

    cap_state_t       state, next_state;
    logic [CNT_W-1:0] issued;
    logic [CNT_W-1:0] accepted;
    logic [X_W-1:0]   wx;
    logic [Y_W-1:0]   wy;
    logic             push, pop, flush, issue;
    logic [1:0]       occ, occ_next;
    pix_entry_t       din, head;
    logic             unused_coord;

    assign pix_valid = (occ != 2'd0);
    assign pop       = pix_valid && pix_ready;
    assign flush     = (state == CAPTURE) && abort;
    // A pixel is accepted only if it answers last cycle's enable.
    assign push      = (state == CAPTURE) && !abort && cam_valid && camera_en;
    // Occupancy after this edge already includes the pixel landing now, so
    // one free slot is enough to cover the pixel requested by this edge.
    assign occ_next  = flush ? 2'd0 : occ + {1'b0, push} - {1'b0, pop};

    assign din.data = cam_data;
    assign din.x    = COORD_W'(wx);
    assign din.y    = COORD_W'(wy);
    assign din.sof  = (accepted == '0);
    assign din.eol  = (wx == X_W'(IMG_W - 1));
    assign din.eof  = (accepted == CNT_W'(NPIX - 1));

    pix_skid_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (din),
        .head  (head),
        .occ   (occ)
    );

    assign pix_data     = head.data;
    assign pix_x        = head.x[X_W-1:0];
    assign pix_y        = head.y[Y_W-1:0];
    assign pix_sof      = head.sof;
    assign pix_eol      = head.eol;
    assign pix_eof      = head.eof;
    assign unused_coord = ^{head.x, head.y};

    assign done    = (state == DONE);
    assign aborted = (state == ABORT);

    always_comb begin
        next_state = state;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = CAPTURE;
                    issue      = 1'b1;
                end
            end
            CAPTURE: begin
                if (abort) begin
                    next_state = ABORT;
                end else begin
                    if (pop && head.eof)
                        next_state = DONE;
                    issue = (issued < CNT_W'(NPIX)) && (occ_next != 2'd2);
                end
            end
            DONE:    next_state = IDLE;
            ABORT:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            camera_en <= 1'b0;
            busy      <= 1'b0;
            frame_cnt <= 16'd0;
            proto_err <= 1'b0;
            issued    <= '0;
            accepted  <= '0;
            wx        <= '0;
            wy        <= '0;
        end else begin
            state     <= next_state;
            camera_en <= issue;
            busy      <= (next_state != IDLE);
            if (state == IDLE && start) begin
                issued    <= CNT_W'(1);
                accepted  <= '0;
                wx        <= '0;
                wy        <= '0;
                proto_err <= 1'b0;
            end else begin
                if (issue)
                    issued <= issued + 1'b1;
                if (push) begin
                    accepted <= accepted + 1'b1;
                    if (wx == X_W'(IMG_W - 1)) begin
                        wx <= '0;
                        wy <= wy + 1'b1;
                    end else begin
                        wx <= wx + 1'b1;
                    end
                end
                // The straggler pixel of an aborted frame is expected, not an error.
                if (cam_valid && !camera_en && state != ABORT)
                    proto_err <= 1'b1;
            end
            if (state == DONE)
                frame_cnt <= frame_cnt + 16'd1;
        end
    end
endmodule
